// File: rtl/logic_axi4_lite_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : logic_axi4_lite_register_bank
// Purpose  : AXI4-Lite slave register bank. Independent one-entry AW and W
//            hold slots feed a strobed commit into word-wide registers.
//            Out-of-range indices answer SLVERR and never touch storage.
//            All register contents are exported as one flat vector.
// Revision : 1.0 - initial release
// ============================================================================
module logic_axi4_lite_register_bank #(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 8,
  parameter int REGISTERS     = 16
) (
  input  logic                                aclk,
  input  logic                                areset_n,
  // Write address channel
  input  logic                                awvalid,
  output logic                                awready,
  input  logic [ADDRESS_WIDTH-1:0]            awaddr,
  input  logic [2:0]                          awprot,
  // Write data channel
  input  logic                                wvalid,
  output logic                                wready,
  input  logic [8*DATA_BYTES-1:0]             wdata,
  input  logic [DATA_BYTES-1:0]               wstrb,
  // Write response channel
  output logic                                bvalid,
  input  logic                                bready,
  output logic [1:0]                          bresp,
  // Read address channel
  input  logic                                arvalid,
  output logic                                arready,
  input  logic [ADDRESS_WIDTH-1:0]            araddr,
  input  logic [2:0]                          arprot,
  // Read data channel
  output logic                                rvalid,
  input  logic                                rready,
  output logic [8*DATA_BYTES-1:0]             rdata,
  output logic [1:0]                          rresp,
  // Flat export of every register
  output logic [REGISTERS*8*DATA_BYTES-1:0]   registers
);

  localparam int         DW          = 8 * DATA_BYTES;
  localparam int         LSB         = $clog2(DATA_BYTES);
  localparam int         IW          = ADDRESS_WIDTH - LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Storage is a packed array so that word i lands at bits [i*DW +: DW].
  logic [REGISTERS-1:0][DW-1:0] regs_q, regs_d;

  // Write hold slots
  logic                  aw_held_q, aw_held_d;
  logic [IW-1:0]         aw_idx_q,  aw_idx_d;
  logic                  w_held_q,  w_held_d;
  logic [DW-1:0]         wdata_q,   wdata_d;
  logic [DATA_BYTES-1:0] wstrb_q,   wstrb_d;

  // Write response
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;

  // Read response
  logic                  rvalid_q,  rvalid_d;
  logic [DW-1:0]         rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [IW-1:0]         ar_idx;
  logic [DW-1:0]         rd_word;

  // Protection bits and sub-word address bits carry no meaning here.
  logic                  unused_inputs;
  assign unused_inputs = ^{awprot, arprot, awaddr, araddr};

  // True when a word index addresses an implemented register.
  function automatic logic idx_in_range(input logic [IW-1:0] idx);
    return 32'(idx) < 32'(REGISTERS);
  endfunction

  // ---------------------------------------------------------------------------
  // Handshakes. A full slot refuses new beats until the commit drains it, which
  // is what back-pressures AW/W while an unaccepted B response is pending.
  // ---------------------------------------------------------------------------
  assign awready = !aw_held_q;
  assign wready  = !w_held_q;
  assign arready = !rvalid_q || rready;

  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid  && wready;
  assign ar_hs   = arvalid && arready;

  // Both halves of the write present and the B channel able to take a response.
  assign commit  = aw_held_q && w_held_q && (!bvalid_q || bready);

  assign ar_idx  = araddr[ADDRESS_WIDTH-1:LSB];

  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign registers = regs_q;

  // Next state of the AW/W hold slots and the write response channel.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = awaddr[ADDRESS_WIDTH-1:LSB];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end

    if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end

    // A handshake cannot coincide with a commit: the slot being drained is
    // full, so its ready is low in the same cycle.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = idx_in_range(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Strobed byte update of the addressed register on commit.
  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      for (int i = 0; i < REGISTERS; i++) begin
        // Implemented indices always fit in IW bits, so an out-of-range
        // index never matches and the write is dropped.
        if (aw_idx_q == IW'(i)) begin
          for (int b = 0; b < DATA_BYTES; b++) begin
            if (wstrb_q[b]) begin
              regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Read mux over current storage; out-of-range indices read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (ar_idx == IW'(i)) begin
        rd_word = regs_q[i];
      end
    end
  end

  // Next state of the read response; data is held until rready.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
    // The mux reads regs_q, so a read colliding with a commit returns the
    // value from before the write.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = idx_in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Control and response flops; reset discards held beats and pending responses.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Register storage.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logic_axi4_lite_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_axi4_lite_register_bank
// Purpose  : Directed self-checking bench for the AXI4-Lite register bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_axi4_lite_register_bank;

  localparam int DB = 4;
  localparam int AW = 8;
  localparam int NR = 16;
  localparam int DW = 8 * DB;

  logic              aclk = 1'b0;
  logic              areset_n;
  logic              awvalid, awready;
  logic [AW-1:0]     awaddr;
  logic [2:0]        awprot;
  logic              wvalid, wready;
  logic [DW-1:0]     wdata;
  logic [DB-1:0]     wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [AW-1:0]     araddr;
  logic [2:0]        arprot;
  logic              rvalid, rready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic [NR*DW-1:0]  registers;

  int n_checks = 0;
  int n_errors = 0;

  logic_axi4_lite_register_bank #(
    .DATA_BYTES    (DB),
    .ADDRESS_WIDTH (AW),
    .REGISTERS     (NR)
  ) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .awprot    (awprot),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .bvalid    (bvalid),
    .bready    (bready),
    .bresp     (bresp),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arprot    (arprot),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .registers (registers)
  );

  always #5 aclk = ~aclk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_word(input int i);
    return registers[i*DW +: DW];
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // AW and W in the same cycle, bready high; response expected two cycles on.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp, input string tag);
    awvalid = 1'b1; awaddr = addr;
    wvalid  = 1'b1; wdata  = data; wstrb = strb;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check_value({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    check_value({tag, "_bresp"},  32'(bresp),  32'(exp_resp));
    tick();
  endtask

  // Single read with rready high; data expected one cycle after AR.
  task automatic do_read(input logic [7:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string tag);
    arvalid = 1'b1; araddr = addr;
    tick();
    arvalid = 1'b0;
    check_value({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check_value({tag, "_rdata"},  rdata,       exp_data);
    check_value({tag, "_rresp"},  32'(rresp),  32'(exp_resp));
    tick();
  endtask

  initial begin
    areset_n = 1'b0;
    awvalid = 1'b0; awaddr = '0; awprot = 3'b000;
    wvalid  = 1'b0; wdata  = '0; wstrb  = '0;
    bready  = 1'b1;
    arvalid = 1'b0; araddr = '0; arprot = 3'b000;
    rready  = 1'b1;

    // ---- Reset state ----
    tick(); tick();
    check_value("rst_awready", 32'(awready), 32'd1);
    check_value("rst_wready",  32'(wready),  32'd1);
    check_value("rst_arready", 32'(arready), 32'd1);
    check_value("rst_bvalid",  32'(bvalid),  32'd0);
    check_value("rst_rvalid",  32'(rvalid),  32'd0);
    check_value("rst_rdata",   rdata,        32'd0);
    check_value("rst_reg0",    reg_word(0),  32'd0);
    areset_n = 1'b1;
    tick();

    // ---- Reset mid-write ----
    do_write(8'h04, 32'hAAAA5555, 4'hF, 2'b00, "pre_rst_wr");
    check_value("pre_rst_reg1", reg_word(1), 32'hAAAA5555);
    awvalid = 1'b1; awaddr = 8'h10;
    tick();
    awvalid = 1'b0;
    check_value("aw_only_awready", 32'(awready), 32'd0);
    #3 areset_n = 1'b0;
    #1;
    check_value("midrst_awready", 32'(awready), 32'd1);
    check_value("midrst_wready",  32'(wready),  32'd1);
    check_value("midrst_arready", 32'(arready), 32'd1);
    check_value("midrst_bvalid",  32'(bvalid),  32'd0);
    check_value("midrst_rvalid",  32'(rvalid),  32'd0);
    check_value("midrst_reg1",    reg_word(1),  32'd0);
    @(posedge aclk);
    #1 areset_n = 1'b1;
    tick();
    do_read(8'h04, 32'd0, 2'b00, "post_rst_rd");

    // ---- Full write, latency and read back ----
    awvalid = 1'b1; awaddr = 8'h08;
    wvalid  = 1'b1; wdata  = 32'hDEADBEEF; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_value("lat_t1_bvalid", 32'(bvalid), 32'd0);
    tick();
    check_value("lat_t2_bvalid", 32'(bvalid), 32'd1);
    check_value("lat_t2_bresp",  32'(bresp),  32'd0);
    check_value("lat_t2_reg2",   reg_word(2), 32'hDEADBEEF);
    tick();
    check_value("lat_bvalid_clr", 32'(bvalid), 32'd0);
    do_read(8'h08, 32'hDEADBEEF, 2'b00, "rd_08");

    // ---- Strobes, W three cycles ahead of AW ----
    wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'b0101;
    tick();
    wvalid = 1'b0;
    check_value("strb_wready_a", 32'(wready), 32'd0);
    tick();
    tick();
    check_value("strb_wready_b", 32'(wready), 32'd0);
    check_value("strb_reg2_old", reg_word(2), 32'hDEADBEEF);
    awvalid = 1'b1; awaddr = 8'h0A;  // unaligned, resolves to word 2
    tick();
    awvalid = 1'b0;
    check_value("strb_wready_c", 32'(wready), 32'd0);
    tick();
    check_value("strb_bvalid", 32'(bvalid),   32'd1);
    check_value("strb_reg2",   reg_word(2),   32'hDE22BE44);
    check_value("strb_wready", 32'(wready),   32'd1);
    tick();

    // ---- Zero strobe ----
    do_write(8'h08, 32'hFFFFFFFF, 4'h0, 2'b00, "zero_strb");
    check_value("zero_strb_reg2", reg_word(2), 32'hDE22BE44);

    // ---- Out of range ----
    do_write(8'h40, 32'hFFFFFFFF, 4'hF, 2'b10, "oor_wr");
    check_value("oor_reg0",  reg_word(0),  32'd0);
    check_value("oor_reg15", reg_word(15), 32'd0);
    do_read(8'h40, 32'd0, 2'b10, "oor_rd");

    // ---- Write backpressure ----
    bready = 1'b0;
    awvalid = 1'b1; awaddr = 8'h10;
    wvalid  = 1'b1; wdata  = 32'h01010101; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check_value("bp_first_bvalid", 32'(bvalid), 32'd1);
    awvalid = 1'b1; awaddr = 8'h14;
    wvalid  = 1'b1; wdata  = 32'h02020202; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_value("bp_awready", 32'(awready), 32'd0);
      check_value("bp_wready",  32'(wready),  32'd0);
      check_value("bp_bvalid",  32'(bvalid),  32'd1);
      check_value("bp_bresp",   32'(bresp),   32'd0);
      check_value("bp_reg5",    reg_word(5),  32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    check_value("bp_rel_bvalid",  32'(bvalid),  32'd1);
    check_value("bp_rel_reg5",    reg_word(5),  32'h02020202);
    check_value("bp_rel_awready", 32'(awready), 32'd1);
    tick();
    check_value("bp_done_bvalid", 32'(bvalid),  32'd0);

    // ---- Read backpressure ----
    rready = 1'b0;
    arvalid = 1'b1; araddr = 8'h10;
    tick();
    araddr = 8'h14;
    check_value("rbp_rvalid", 32'(rvalid), 32'd1);
    check_value("rbp_rdata",  rdata,       32'h01010101);
    for (int k = 0; k < 3; k++) begin
      check_value("rbp_arready",    32'(arready), 32'd0);
      check_value("rbp_rdata_hold", rdata,        32'h01010101);
      tick();
    end
    rready = 1'b1;
    tick();
    arvalid = 1'b0;
    check_value("rbp_second_rdata", rdata, 32'h02020202);
    tick();
    check_value("rbp_rvalid_clr", 32'(rvalid), 32'd0);

    // ---- Back-to-back reads ----
    arvalid = 1'b1; araddr = 8'h08;
    tick();
    araddr = 8'h14;
    check_value("b2b_rdata0", rdata, 32'hDE22BE44);
    tick();
    arvalid = 1'b0;
    check_value("b2b_rvalid1", 32'(rvalid), 32'd1);
    check_value("b2b_rdata1",  rdata,       32'h02020202);
    tick();

    // ---- Read / commit collision ----
    do_write(8'h0C, 32'h12345678, 4'hF, 2'b00, "col_pre");
    awvalid = 1'b1; awaddr = 8'h0C;
    wvalid  = 1'b1; wdata  = 32'hCAFEF00D; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 8'h0C;   // AR in the commit cycle
    tick();
    arvalid = 1'b0;
    check_value("col_rdata",  rdata,       32'h12345678);
    check_value("col_bvalid", 32'(bvalid), 32'd1);
    check_value("col_reg3",   reg_word(3), 32'hCAFEF00D);
    tick();
    do_read(8'h0C, 32'hCAFEF00D, 2'b00, "col_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
